// File: rtl/fwd_hazard_ctrl.sv
// rtl/fwd_hazard_ctrl.sv - decode-stage forwarding select and load-use hazard controller
// Tracks in-flight destinations in EX/MEM/WB shadows and registers EX operand mux selects.
module fwd_hazard_ctrl #(
  parameter int REG_ADDR_W = 5
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_id_valid,
  input  logic [REG_ADDR_W-1:0] i_id_rs1,
  input  logic [REG_ADDR_W-1:0] i_id_rs2,
  input  logic                  i_id_rs1_used,
  input  logic                  i_id_rs2_used,
  input  logic [REG_ADDR_W-1:0] i_id_rd,
  input  logic                  i_id_rd_wren,
  input  logic                  i_id_is_load,
  input  logic                  i_flush,
  output logic                  o_stall_pc,
  output logic                  o_stall_if_id,
  output logic                  o_flush_id_ex,
  output logic [2:0]            o_fwd_sel_a,
  output logic [2:0]            o_fwd_sel_b
);

  localparam logic [2:0] SEL_RF   = 3'b000;
  localparam logic [2:0] SEL_EXM  = 3'b001;
  localparam logic [2:0] SEL_MWB  = 3'b010;
  localparam logic [2:0] SEL_RET  = 3'b011;
  localparam logic [2:0] SEL_ZERO = 3'b100;

  typedef enum logic {ST_RUN, ST_STALL} state_t;

  state_t                state_q;
  logic                  ex_valid_q, ex_wren_q, ex_load_q;
  logic [REG_ADDR_W-1:0] ex_rd_q;
  logic                  mem_valid_q, mem_wren_q;
  logic [REG_ADDR_W-1:0] mem_rd_q;
  logic                  wb_valid_q, wb_wren_q;
  logic [REG_ADDR_W-1:0] wb_rd_q;
  logic                  ex_valid_d, ex_wren_d, ex_load_d;
  logic [REG_ADDR_W-1:0] ex_rd_d;
  logic [2:0]            sel_a_q, sel_a_d, sel_b_q, sel_b_d;
  logic                  load_use, stall;

  function automatic logic hit(input logic v, input logic wr,
                               input logic [REG_ADDR_W-1:0] rd,
                               input logic [REG_ADDR_W-1:0] rs);
    return v && wr && (rd != '0) && (rd == rs);
  endfunction

  // Youngest producer wins; x0 and unread operands take the constant-zero path.
  function automatic logic [2:0] pick_sel(input logic used,
                                          input logic [REG_ADDR_W-1:0] rs,
                                          input logic ex_hit, input logic mem_hit,
                                          input logic wb_hit);
    if (!used || rs == '0) return SEL_ZERO;
    if (ex_hit)            return SEL_EXM;
    if (mem_hit)           return SEL_MWB;
    if (wb_hit)            return SEL_RET;
    return SEL_RF;
  endfunction

  assign load_use = i_id_valid && ex_load_q &&
                    ((i_id_rs1_used && hit(ex_valid_q, ex_wren_q, ex_rd_q, i_id_rs1)) ||
                     (i_id_rs2_used && hit(ex_valid_q, ex_wren_q, ex_rd_q, i_id_rs2)));

  assign stall         = !i_reset && !i_flush && (state_q == ST_RUN) && load_use;
  assign o_stall_pc    = stall;
  assign o_stall_if_id = stall;
  assign o_flush_id_ex = stall;
  assign o_fwd_sel_a   = sel_a_q;
  assign o_fwd_sel_b   = sel_b_q;

  always_comb begin
    ex_valid_d = 1'b0;
    ex_wren_d  = 1'b0;
    ex_load_d  = 1'b0;
    ex_rd_d    = '0;
    if (i_id_valid && !stall && !i_flush) begin
      ex_valid_d = 1'b1;
      ex_wren_d  = i_id_rd_wren;
      ex_load_d  = i_id_is_load;
      ex_rd_d    = i_id_rd;
    end
  end

  always_comb begin
    sel_a_d = SEL_RF;
    sel_b_d = SEL_RF;
    if (!stall && !i_flush) begin
      sel_a_d = pick_sel(i_id_rs1_used, i_id_rs1,
                         hit(ex_valid_q, ex_wren_q, ex_rd_q, i_id_rs1),
                         hit(mem_valid_q, mem_wren_q, mem_rd_q, i_id_rs1),
                         hit(wb_valid_q, wb_wren_q, wb_rd_q, i_id_rs1));
      sel_b_d = pick_sel(i_id_rs2_used, i_id_rs2,
                         hit(ex_valid_q, ex_wren_q, ex_rd_q, i_id_rs2),
                         hit(mem_valid_q, mem_wren_q, mem_rd_q, i_id_rs2),
                         hit(wb_valid_q, wb_wren_q, wb_rd_q, i_id_rs2));
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= ST_RUN;
      ex_valid_q  <= 1'b0;
      ex_wren_q   <= 1'b0;
      ex_load_q   <= 1'b0;
      ex_rd_q     <= '0;
      mem_valid_q <= 1'b0;
      mem_wren_q  <= 1'b0;
      mem_rd_q    <= '0;
      wb_valid_q  <= 1'b0;
      wb_wren_q   <= 1'b0;
      wb_rd_q     <= '0;
      sel_a_q     <= SEL_RF;
      sel_b_q     <= SEL_RF;
    end else begin
      wb_valid_q  <= mem_valid_q;
      wb_wren_q   <= mem_wren_q;
      wb_rd_q     <= mem_rd_q;
      mem_valid_q <= ex_valid_q;
      mem_wren_q  <= ex_wren_q;
      mem_rd_q    <= ex_rd_q;
      ex_valid_q  <= ex_valid_d;
      ex_wren_q   <= ex_wren_d;
      ex_load_q   <= ex_load_d;
      ex_rd_q     <= ex_rd_d;
      sel_a_q     <= sel_a_d;
      sel_b_q     <= sel_b_d;
      // The bubble moves the load into MEM, so one stall cycle always suffices.
      case (state_q)
        ST_RUN:   state_q <= stall ? ST_STALL : ST_RUN;
        ST_STALL: state_q <= ST_RUN;
        default:  state_q <= ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// tb/tb_fwd_hazard_ctrl.sv - directed-vector bench for fwd_hazard_ctrl
module tb_fwd_hazard_ctrl;

  logic       clk = 1'b0;
  logic       i_reset, i_id_valid, i_id_rs1_used, i_id_rs2_used;
  logic       i_id_rd_wren, i_id_is_load, i_flush;
  logic [4:0] i_id_rs1, i_id_rs2, i_id_rd;
  logic       o_stall_pc, o_stall_if_id, o_flush_id_ex;
  logic [2:0] o_fwd_sel_a, o_fwd_sel_b;

  int n_checks = 0;
  int n_errors = 0;

  fwd_hazard_ctrl #(.REG_ADDR_W(5)) dut (
    .i_clk         (clk),
    .i_reset       (i_reset),
    .i_id_valid    (i_id_valid),
    .i_id_rs1      (i_id_rs1),
    .i_id_rs2      (i_id_rs2),
    .i_id_rs1_used (i_id_rs1_used),
    .i_id_rs2_used (i_id_rs2_used),
    .i_id_rd       (i_id_rd),
    .i_id_rd_wren  (i_id_rd_wren),
    .i_id_is_load  (i_id_is_load),
    .i_flush       (i_flush),
    .o_stall_pc    (o_stall_pc),
    .o_stall_if_id (o_stall_if_id),
    .o_flush_id_ex (o_flush_id_ex),
    .o_fwd_sel_a   (o_fwd_sel_a),
    .o_fwd_sel_b   (o_fwd_sel_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic id(input logic v, input logic [4:0] rs1, input logic u1,
                    input logic [4:0] rs2, input logic u2,
                    input logic [4:0] rd, input logic wr, input logic ld);
    i_id_valid    = v;
    i_id_rs1      = rs1;
    i_id_rs1_used = u1;
    i_id_rs2      = rs2;
    i_id_rs2_used = u2;
    i_id_rd       = rd;
    i_id_rd_wren  = wr;
    i_id_is_load  = ld;
    i_flush       = 1'b0;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sels(input string tag, input logic [2:0] a, input logic [2:0] b);
    check({tag, "_sel_a"}, {5'd0, o_fwd_sel_a}, {5'd0, a});
    check({tag, "_sel_b"}, {5'd0, o_fwd_sel_b}, {5'd0, b});
  endtask

  task automatic stalls(input string tag, input logic e);
    check({tag, "_stall_pc"},    {7'd0, o_stall_pc},    {7'd0, e});
    check({tag, "_stall_if_id"}, {7'd0, o_stall_if_id}, {7'd0, e});
    check({tag, "_flush_id_ex"}, {7'd0, o_flush_id_ex}, {7'd0, e});
  endtask

  initial begin
    i_reset = 1'b1;
    id(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    sels("reset", 3'b000, 3'b000);
    stalls("reset", 1'b0);
    i_reset = 1'b0;

    // ALU chain: distance 1, 2, 3 and beyond
    id(1, 1, 1, 2, 1, 5, 1, 0); stalls("A", 1'b0); tick(); sels("A", 3'b000, 3'b000);
    id(1, 5, 1, 6, 1, 8, 1, 0); tick(); sels("B", 3'b001, 3'b000);
    id(1, 5, 1, 8, 1, 9, 1, 0); tick(); sels("C", 3'b010, 3'b001);
    id(1, 5, 1, 9, 1, 0, 0, 0); tick(); sels("D", 3'b011, 3'b001);
    id(1, 5, 1, 8, 1, 0, 0, 0); tick(); sels("E", 3'b000, 3'b011);

    // Priority and x0
    id(1, 0, 0, 0, 0, 7, 1, 0); tick(); sels("F", 3'b100, 3'b100);
    id(1, 0, 0, 0, 0, 7, 1, 0); tick(); sels("G", 3'b100, 3'b100);
    id(1, 7, 1, 0, 1, 0, 1, 0); tick(); sels("H", 3'b001, 3'b100);
    id(1, 1, 1, 0, 1, 0, 0, 0); tick(); sels("I", 3'b000, 3'b100);

    // Load-use: exactly one stall cycle, then MEM forward
    id(1, 2, 1, 0, 0, 3, 1, 1); stalls("J", 1'b0); tick(); sels("J", 3'b000, 3'b100);
    id(1, 4, 1, 3, 1, 10, 1, 0); stalls("K_detect", 1'b1);
    tick(); sels("K_stall", 3'b000, 3'b000); stalls("K_hold", 1'b0);
    tick(); sels("K_fwd", 3'b000, 3'b010);
    id(1, 10, 1, 0, 0, 11, 1, 0); stalls("L", 1'b0); tick(); sels("L", 3'b001, 3'b100);

    // Unused operand behind a load
    id(1, 0, 0, 0, 0, 3, 1, 1); tick(); sels("M", 3'b100, 3'b100);
    id(1, 3, 0, 1, 1, 0, 0, 0); stalls("N", 1'b0); tick(); sels("N", 3'b100, 3'b000);

    // Flush dominates load-use
    id(1, 0, 0, 0, 0, 3, 1, 1); tick(); sels("O", 3'b100, 3'b100);
    id(1, 3, 1, 3, 1, 12, 1, 0); i_flush = 1'b1; #1;
    stalls("P_flush", 1'b0); tick(); sels("P_flush", 3'b000, 3'b000);
    id(1, 3, 1, 11, 1, 0, 0, 0); stalls("Q", 1'b0); tick(); sels("Q", 3'b010, 3'b000);
    id(1, 12, 1, 3, 1, 0, 0, 0); tick(); sels("R", 3'b000, 3'b011);

    // Reset while a stall is pending
    id(1, 0, 0, 0, 0, 3, 1, 1); tick();
    id(1, 3, 1, 0, 0, 13, 1, 0); stalls("T_detect", 1'b1);
    i_reset = 1'b1; #1; stalls("T_in_reset", 1'b0);
    tick(); sels("rst1", 3'b000, 3'b000); stalls("rst1", 1'b0);
    tick(); sels("rst2", 3'b000, 3'b000);
    i_reset = 1'b0; #1;
    stalls("rst_release", 1'b0);
    tick(); sels("rst_release", 3'b000, 3'b100);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
